// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier: N-cycle latency, registered product and finish flag.
// Optional busy status port is enabled by defining MULTIPLIER_BUSY_EN.
module multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
`ifdef MULTIPLIER_BUSY_EN
    output logic           busy,
`endif
    output logic [2*N-1:0] out,
    output logic           finish
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic            start_d_r;
    logic            start_edge_s;
    logic            last_iter_s;
    logic [2*N-1:0]  mcand_r;
    logic [N-1:0]    mplier_r;
    logic [2*N-1:0]  prod_r;
    logic [CW-1:0]   cnt_r;
    logic [2*N-1:0]  out_r;
    logic            finish_r;
    logic [2*N-1:0]  addend_s;
    logic [2*N-1:0]  sum_s;

    assign start_edge_s = start & ~start_d_r;
    assign last_iter_s  = (cnt_r == LAST_ITER);
    assign sum_s        = prod_r + addend_s;

    // Partial-product addend: shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        addend_s = {(2*N){1'b0}};
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {(2*N){1'b0}};
        end
    end

    // Next-state logic; start edges are only honoured outside BUSY.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_edge_s) begin
                    next_state_s = BUSY;
                end else begin
                    next_state_s = state_r;
                end
            end
            BUSY: begin
                if (last_iter_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = BUSY;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register and start-edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            start_d_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            start_d_r <= start;
        end
    end

    // Datapath: operand capture, one shift-add step per BUSY cycle, result load on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= {(2*N){1'b0}};
            mplier_r <= {N{1'b0}};
            prod_r   <= {(2*N){1'b0}};
            cnt_r    <= {CW{1'b0}};
            out_r    <= {(2*N){1'b0}};
            finish_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start_edge_s) begin
                        mcand_r  <= {{N{1'b0}}, a_in};
                        mplier_r <= b_in;
                        prod_r   <= {(2*N){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        finish_r <= 1'b0;
                    end
                end
                BUSY: begin
                    // The multiplicand shifts once per step, so it always carries the iteration weight.
                    prod_r   <= sum_s;
                    mcand_r  <= {mcand_r[2*N-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[N-1:1]};
                    cnt_r    <= cnt_r + CW'(1'b1);
                    if (last_iter_s) begin
                        out_r    <= sum_s;
                        finish_r <= 1'b1;
                    end
                end
                default: begin
                    finish_r <= 1'b0;
                end
            endcase
        end
    end

    assign out    = out_r;
    assign finish = finish_r;

`ifdef MULTIPLIER_BUSY_EN
    logic busy_r;

    // Busy flag registered from the next state so it tracks the FSM exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == BUSY);
        end
    end

    assign busy = busy_r;
`endif

endmodule

// File: tb/tb_multiplier.sv
// Directed scoreboard bench for the shift-add multiplier at N=5 with a 100 ns clock.
module tb_multiplier;

    localparam int N = 5;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic [2*N-1:0] out;
    logic           finish;
`ifdef MULTIPLIER_BUSY_EN
    logic           busy;
`endif

    int             n_tests;
    int             n_fail;
    logic [2*N-1:0] exp_q[$];
    logic [2*N-1:0] prev_out;

    multiplier #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
`ifdef MULTIPLIER_BUSY_EN
        .busy   (busy),
`endif
        .out    (out),
        .finish (finish)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_busy(input string tag, input logic exp);
`ifdef MULTIPLIER_BUSY_EN
        check(tag, {31'd0, busy}, {31'd0, exp});
`endif
    endtask

    // Drive operands with a start edge, take the capture edge, optionally record the expected product.
    task automatic capture(input int a, input int b, input bit push);
        int p;
        a_in  = N'(a);
        b_in  = N'(b);
        start = 1'b1;
        p = a * b;
        if (push) exp_q.push_back((2*N)'(p));
        tick();
        check("finish_drop", {31'd0, finish}, 32'd0);
        check("out_retained", {22'd0, out}, {22'd0, prev_out});
        check_busy("busy_set", 1'b1);
    endtask

    // Wait for finish, checking latency from the capture edge and the held output meanwhile.
    task automatic wait_done(input int elapsed);
        int cyc;
        bit got;
        logic [2*N-1:0] exp;
        cyc = elapsed;
        got = 1'b0;
        while (cyc < N + 3 && !got) begin
            tick();
            cyc++;
            if (finish === 1'b1) begin
                got = 1'b1;
            end else begin
                check("hold_out", {22'd0, out}, {22'd0, prev_out});
            end
        end
        check("latency", cyc, N);
        check_busy("busy_clear", 1'b0);
        check("sb_size", exp_q.size(), 32'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : {(2*N){1'b1}};
        check("product", {22'd0, out}, {22'd0, exp});
        prev_out = exp;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        prev_out = {(2*N){1'b0}};
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = {N{1'b0}};
        b_in     = {N{1'b0}};

        // Reset state
        tick();
        check("rst_out", {22'd0, out}, 32'd0);
        check("rst_finish", {31'd0, finish}, 32'd0);
        check_busy("rst_busy", 1'b0);

        // 26 * 30 after two idle cycles
        reset = 1'b0;
        tick();
        tick();
        check("idle_finish", {31'd0, finish}, 32'd0);
        capture(26, 30, 1'b1);
        wait_done(0);

        // 13 * 13: finish drops on capture, out holds 780 until done
        start = 1'b0;
        tick();
        tick();
        capture(13, 13, 1'b1);
        wait_done(0);

        // Zero operand still takes N cycles
        start = 1'b0;
        tick();
        capture(0, 17, 1'b1);
        wait_done(0);

        // Maximum operands
        start = 1'b0;
        tick();
        capture(31, 31, 1'b1);
        wait_done(0);

        // Start held high across DONE must not retrigger
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_out", {22'd0, out}, 32'd961);
            check("held_finish", {31'd0, finish}, 32'd1);
            check_busy("held_busy", 1'b0);
        end

        // A start edge on cycle 2 of BUSY is ignored
        start = 1'b0;
        tick();
        capture(7, 9, 1'b1);
        start = 1'b0;
        tick();
        a_in  = N'(3);
        b_in  = N'(4);
        start = 1'b1;
        tick();
        wait_done(2);
        tick();
        check("no_queue_out", {22'd0, out}, 32'd63);
        check("no_queue_finish", {31'd0, finish}, 32'd1);

        // Reset on cycle 3 of BUSY aborts without a finish pulse
        start = 1'b0;
        tick();
        capture(5, 6, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_out", {22'd0, out}, 32'd0);
        check("abort_finish", {31'd0, finish}, 32'd0);
        check_busy("abort_busy", 1'b0);
        prev_out = {(2*N){1'b0}};

        // Reset wins over start; start high on the first free edge counts as an edge
        start = 1'b1;
        tick();
        check("rst_prio_finish", {31'd0, finish}, 32'd0);
        check_busy("rst_prio_busy", 1'b0);
        reset = 1'b0;
        capture(21, 11, 1'b1);
        wait_done(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
